// File: rtl/div_pkg.sv
// div_pkg: shared types and rate constants for the clock-divider controller.
//   div_state_t : controller state (IDLE, RUN, DRAIN)
//   SYS_CLK_HZ  : board system clock frequency
//   HALF_1HZ    : half-period in system cycles for a 1 Hz output
//   HALF_1KHZ   : half-period in system cycles for a 1 kHz output
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } div_state_t;

    localparam int unsigned SYS_CLK_HZ = 100_000_000;
    localparam int unsigned HALF_1HZ   = SYS_CLK_HZ / 2;
    localparam int unsigned HALF_1KHZ  = SYS_CLK_HZ / 2_000;

endpackage

// File: rtl/div_core.sv
// div_core: half-period counter plus the divided-clock toggle register.
//   clk, rst : system clock, synchronous active-high reset
//   clear    : force counter to 0 and div_clk low (highest priority after rst)
//   load     : start a run: counter to 1, div_clk low
//   en       : advance the counter / toggle at the half-period boundary
//   half     : active half-period (never 0, clamped upstream)
//   toggle_c : combinational strobe, high on cycles where div_clk will flip
//   div_clk  : registered divided clock
module div_core #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] half,
    output logic             toggle_c,
    output logic             div_clk
);

    logic [CNT_W-1:0] count;

    // Counter reaching the half-period marks a phase boundary.
    assign toggle_c = en && (count >= half);

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            div_clk <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            div_clk <= 1'b0;
        end else if (load) begin
            count   <= CNT_W'(1);
            div_clk <= 1'b0;
        end else if (toggle_c) begin
            count   <= CNT_W'(1);
            div_clk <= ~div_clk;
        end else if (en) begin
            count   <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/div_rate_ctrl.sv
// div_rate_ctrl: run-time controller for the divided board clock.
// Starts/stops the divider, takes new half-period/burst settings over a
// valid/ready handshake and applies them only on clk_o toggle edges.
//   clk_i, rst_i       : system clock, synchronous active-high reset
//   start_i, stop_i    : level-sampled run requests
//   cfg_valid_i/ready_o: config handshake
//   cfg_half_i         : half-period in clk_i cycles (0 treated as 1)
//   cfg_burst_i        : full output periods per run (0 = free-run)
//   clk_o              : divided clock
//   tick_o             : pulse on every clk_o rise
//   done_o             : pulse when a burst completes
//   busy_o             : controller not idle
module div_rate_ctrl
    import div_pkg::*;
#(
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned BURST_W      = 16,
    parameter int unsigned DEFAULT_HALF = HALF_1HZ
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [CNT_W-1:0]   cfg_half_i,
    input  logic [BURST_W-1:0] cfg_burst_i,
    output logic               clk_o,
    output logic               tick_o,
    output logic               done_o,
    output logic               busy_o
);

    div_state_t         state;
    logic [CNT_W-1:0]   active_half;
    logic [CNT_W-1:0]   shadow_half;
    logic [CNT_W-1:0]   half_clamped;
    logic [BURST_W-1:0] active_burst;
    logic [BURST_W-1:0] shadow_burst;
    logic [BURST_W-1:0] period_cnt;
    logic [BURST_W-1:0] period_next;
    logic               pending;
    logic               xfer;
    logic               toggle;
    logic               burst_hit;
    logic               end_run;
    logic               core_load;
    logic               core_en;

    // Handshake, burst completion and run-termination decode.
    always_comb begin
        half_clamped = (cfg_half_i == '0) ? CNT_W'(1) : cfg_half_i;
        xfer         = cfg_valid_i && cfg_ready_o;
        period_next  = period_cnt + BURST_W'(1);
        burst_hit    = (active_burst != '0) && (period_next == active_burst);
        core_en      = (state != IDLE);
        core_load    = (state == IDLE) && start_i && !stop_i;
        end_run      = 1'b0;
        case (state)
            // Low phase stops at once; a falling edge ends on stop or burst.
            RUN:     end_run = (stop_i && !clk_o) ||
                               (toggle && clk_o && (stop_i || burst_hit));
            // In DRAIN clk_o is high, so the only toggle is the final fall.
            DRAIN:   end_run = toggle;
            default: end_run = 1'b0;
        endcase
    end

    div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (end_run),
        .load     (core_load),
        .en       (core_en),
        .half     (active_half),
        .toggle_c (toggle),
        .div_clk  (clk_o)
    );

    // Controller FSM, shadow registers and burst counting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            tick_o       <= 1'b0;
            done_o       <= 1'b0;
            busy_o       <= 1'b0;
            cfg_ready_o  <= 1'b1;
            pending      <= 1'b0;
            period_cnt   <= '0;
            active_half  <= CNT_W'(DEFAULT_HALF);
            active_burst <= '0;
            shadow_half  <= '0;
            shadow_burst <= '0;
        end else begin
            tick_o <= 1'b0;
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        active_half  <= half_clamped;
                        active_burst <= cfg_burst_i;
                    end
                    if (core_load) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (end_run) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        cfg_ready_o <= 1'b1;
                        pending     <= 1'b0;
                        period_cnt  <= '0;
                        done_o      <= toggle && clk_o && burst_hit;
                    end else begin
                        if (toggle) begin
                            if (!clk_o) begin
                                tick_o <= 1'b1;
                            end else begin
                                period_cnt <= period_next;
                            end
                            // Apply shadowed settings on a phase boundary.
                            if (pending) begin
                                active_half  <= shadow_half;
                                active_burst <= shadow_burst;
                                pending      <= 1'b0;
                                cfg_ready_o  <= 1'b1;
                                if (shadow_burst != active_burst) begin
                                    period_cnt <= '0;
                                end
                            end
                        end
                        if (xfer) begin
                            shadow_half  <= half_clamped;
                            shadow_burst <= cfg_burst_i;
                            pending      <= 1'b1;
                            cfg_ready_o  <= 1'b0;
                        end
                        // Reaching here with stop means clk_o is high mid-phase.
                        if (stop_i) begin
                            state       <= DRAIN;
                            cfg_ready_o <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (end_run) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        cfg_ready_o <= 1'b1;
                        pending     <= 1'b0;
                        period_cnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_rate_ctrl.sv
// tb_div_rate_ctrl: scoreboard bench for div_rate_ctrl. Expected clk_o edges
// and done pulses are computed from half/burst arithmetic and queued; a
// monitor pops and compares whenever the DUT shows an edge or pulse.
`timescale 1ns/1ps
module tb_div_rate_ctrl;

    localparam int unsigned CNT_W    = 26;
    localparam int unsigned BURST_W  = 16;
    localparam int unsigned DEF_HALF = 8;
    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_i = 1'b0;
    logic               stop_i = 1'b0;
    logic               cfg_valid_i = 1'b0;
    logic               cfg_ready_o;
    logic [CNT_W-1:0]   cfg_half_i = '0;
    logic [BURST_W-1:0] cfg_burst_i = '0;
    logic               clk_o;
    logic               tick_o;
    logic               done_o;
    logic               busy_o;

    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;
    ev_t  exp_q[$];
    logic prev_clk = 1'b0;

    div_rate_ctrl #(
        .CNT_W        (CNT_W),
        .BURST_W      (BURST_W),
        .DEFAULT_HALF (DEF_HALF)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_half_i  (cfg_half_i),
        .cfg_burst_i (cfg_burst_i),
        .clk_o       (clk_o),
        .tick_o      (tick_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_n <= edge_n + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: still running at edge %0d, required finish", edge_n);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d at edge %0d, required none", kind, edge_n);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_edge", edge_n, e.at);
        end
    endtask

    // Monitor: sampled mid-cycle, reacts to every clk_o edge and done pulse.
    always @(negedge clk_i) begin : monitor
        logic rose;
        logic fell;
        rose = (clk_o === 1'b1) && (prev_clk === 1'b0);
        fell = (clk_o === 1'b0) && (prev_clk === 1'b1);
        check("tick_vs_rise", tick_o, rose);
        if (rose) expect_ev(EV_RISE);
        else if (fell) expect_ev(EV_FALL);
        if (done_o === 1'b1) expect_ev(EV_DONE);
        prev_clk = clk_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (edge_n < e) step();
    endtask

    task automatic push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Reference: tog holds uninterrupted toggle edges (output starts low).
    // A stop sampled while low ends the run at once; while high, the run
    // ends on the next scheduled fall. Returns the edge where busy drops.
    task automatic model_run(input int tog[$], input int t_stop, output int end_e);
        bit lvl;
        lvl   = 1'b0;
        end_e = 0;
        foreach (tog[j]) begin
            if (t_stop > 0 && tog[j] >= t_stop) begin
                if (lvl) begin
                    push_ev(EV_FALL, tog[j]);
                    end_e = tog[j];
                end else begin
                    end_e = t_stop;
                end
                return;
            end
            lvl = ~lvl;
            push_ev(lvl ? EV_RISE : EV_FALL, tog[j]);
            end_e = tog[j];
        end
    endtask

    task automatic start_run(input bit with_cfg, input int half, input int burst, output int s);
        cfg_valid_i = with_cfg;
        cfg_half_i  = CNT_W'(half);
        cfg_burst_i = BURST_W'(burst);
        start_i     = 1'b1;
        step();
        s           = edge_n;
        start_i     = 1'b0;
        cfg_valid_i = 1'b0;
    endtask

    task automatic do_stop(input int t);
        wait_until(t - 1);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
    endtask

    task automatic finish_run(input int e);
        wait_until(e);
        check("idle_busy", busy_o, 0);
        check("idle_ready", cfg_ready_o, 1);
        check("idle_clk", clk_o, 0);
        wait_until(e + 4);
        check("events_drained", exp_q.size(), 0);
    endtask

    initial begin : stim
        int tog[$];
        int s, e, t, h, hv, b, last, x, f, h1, h2, h3;

        // Reset state
        step();
        step();
        rst_i = 1'b0;
        check("rst_clk", clk_o, 0);
        check("rst_tick", tick_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", cfg_ready_o, 1);

        // Free-run with random half (0 must behave as 1) and random stop
        for (int it = 0; it < 5; it++) begin
            hv = $urandom_range(0, 6);
            h  = (hv == 0) ? 1 : hv;
            start_run(1'b1, hv, 0, s);
            check("busy_running", busy_o, 1);
            tog.delete();
            for (int j = 1; j <= 40; j++) tog.push_back(s + j * h);
            t = s + $urandom_range(2, 6 * h + 2);
            model_run(tog, t, e);
            do_stop(t);
            finish_run(e);
        end

        // Directed stop during low phase (offset 2) and high phase (offset 5)
        for (int k = 0; k < 2; k++) begin
            start_run(1'b1, 4, 0, s);
            tog.delete();
            for (int j = 1; j <= 8; j++) tog.push_back(s + j * 4);
            t = s + ((k == 0) ? 2 : 5);
            model_run(tog, t, e);
            do_stop(t);
            if (k == 1) check("drain_busy", busy_o, 1);
            finish_run(e);
        end

        // Bursts; the last one asserts stop on the completion edge
        for (int it = 0; it < 4; it++) begin
            h = $urandom_range(1, 5);
            b = $urandom_range(1, 4);
            start_run(1'b1, h, b, s);
            tog.delete();
            for (int j = 1; j <= 2 * b; j++) tog.push_back(s + j * h);
            last = s + 2 * b * h;
            if (it == 3) begin
                model_run(tog, last, e);
                push_ev(EV_DONE, last);
                do_stop(last);
            end else begin
                model_run(tog, 0, e);
                push_ev(EV_DONE, last);
            end
            finish_run(last);
        end

        // Mid-run reconfiguration with a second offer stalled while pending
        for (int it = 0; it < 2; it++) begin
            h1 = $urandom_range(2, 4);
            h2 = $urandom_range(4, 7);
            h3 = $urandom_range(1, 3);
            start_run(1'b1, h1, 0, s);
            x = s + h1 + 1;
            f = s + 2 * h1;
            tog.delete();
            tog.push_back(s + h1);
            tog.push_back(f);
            tog.push_back(f + h2);
            for (int j = 1; j <= 30; j++) tog.push_back(f + h2 + j * h3);
            t = f + h2 + $urandom_range(2, 4 * h3 + 2);
            model_run(tog, t, e);
            wait_until(x - 1);
            cfg_valid_i = 1'b1;
            cfg_half_i  = CNT_W'(h2);
            cfg_burst_i = '0;
            step();
            check("ready_after_accept", cfg_ready_o, 0);
            cfg_half_i = CNT_W'(h3);
            wait_until(f - 1);
            check("ready_while_pending", cfg_ready_o, 0);
            step();
            check("ready_after_apply", cfg_ready_o, 1);
            step();
            check("ready_second_accept", cfg_ready_o, 0);
            cfg_valid_i = 1'b0;
            do_stop(t);
            finish_run(e);
        end

        // start and stop together in IDLE stays idle
        start_i = 1'b1;
        stop_i  = 1'b1;
        step();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("start_stop_busy", busy_o, 0);
        step();
        step();
        check("start_stop_clk", clk_o, 0);
        check("start_stop_busy_later", busy_o, 0);

        // Reset during a high phase, then a run on the default half-period
        start_run(1'b1, 4, 0, s);
        push_ev(EV_RISE, s + 4);
        push_ev(EV_FALL, s + 6);
        wait_until(s + 5);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_clk", clk_o, 0);
        check("midrst_tick", tick_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_ready", cfg_ready_o, 1);
        start_run(1'b0, 0, 0, s);
        tog.delete();
        for (int j = 1; j <= 6; j++) tog.push_back(s + j * DEF_HALF);
        t = s + 27;
        model_run(tog, t, e);
        do_stop(t);
        finish_run(e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
